// File: rtl/piso_shifter.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready
// handshake and shifts it out one bit per ser_en-terminated bit period.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word active; load_ready=1, ser_out at IDLE_LVL
// SHIFT | word in progress; ser_out holds current bit until ser_en
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_next;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The outgoing bit always sits at the lead end of the register.
  assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_reg[WIDTH-1:1]};

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      ser_out   <= IDLE_LVL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            state     <= SHIFT;
            shift_reg <= load_data;
            bit_cnt   <= '0;
            ser_out   <= lead_bit(load_data);
            ser_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            if (bit_cnt == LAST_CNT) begin
              state     <= IDLE;
              ser_out   <= IDLE_LVL;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 1'b1;
              ser_out   <= lead_bit(shift_next);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: an MSB-first and an LSB-first instance
// driven with hand-computed bit streams.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ser_en = 1'b0;
  logic       load_ready, ser_out, ser_valid, busy, done;

  logic       clr_l = 1'b0;
  logic       load_valid_l = 1'b0;
  logic [7:0] load_data_l = 8'h00;
  logic       ser_en_l = 1'b0;
  logic       load_ready_l, ser_out_l, ser_valid_l, busy_l, done_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_msb (
    .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(ser_out),
    .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_lsb (
    .clk(clk), .clr(clr_l), .load_valid(load_valid_l), .load_ready(load_ready_l),
    .load_data(load_data_l), .ser_en(ser_en_l), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .busy(busy_l), .done(done_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pack the five status outputs so one comparison covers a whole state.
  function automatic logic [7:0] st_msb();
    return {3'b000, ser_out, ser_valid, busy, done, load_ready};
  endfunction

  function automatic logic [7:0] st_lsb();
    return {3'b000, ser_out_l, ser_valid_l, busy_l, done_l, load_ready_l};
  endfunction

  initial begin
    logic [7:0] w;
    logic [7:0] exp_bit;

    // 1: reset held two cycles
    clr = 1'b1; clr_l = 1'b1;
    tick(); tick();
    clr = 1'b0; clr_l = 1'b0;
    chk("reset_msb", st_msb(), 8'b000_0_0_0_0_1);
    chk("reset_lsb", st_lsb(), 8'b000_0_0_0_0_1);

    // ser_en in IDLE does nothing
    ser_en = 1'b1;
    tick();
    chk("idle_ser_en", st_msb(), 8'b000_0_0_0_0_1);

    // 2: 0xA5 MSB first, ser_en tied high
    w = 8'hA5;
    load_valid = 1'b1; load_data = w;
    tick();
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_bit = {7'd0, w[7-i]};
      chk($sformatf("a5_bit%0d", i), st_msb(), {3'b000, exp_bit[0], 4'b1100});
      tick();
    end
    chk("a5_done", st_msb(), 8'b000_0_0_0_1_1);
    tick();
    chk("a5_done_pulse_end", st_msb(), 8'b000_0_0_0_0_1);

    // 3: 0x3C with ser_en every third cycle
    w = 8'h3C;
    ser_en = 1'b0;
    load_valid = 1'b1; load_data = w;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      exp_bit = {7'd0, w[7 - c/3]};
      ser_en = ((c % 3) == 2);
      chk($sformatf("3c_cyc%0d", c), st_msb(), {3'b000, exp_bit[0], 4'b1100});
      tick();
    end
    ser_en = 1'b0;
    chk("3c_done", st_msb(), 8'b000_0_0_0_1_1);
    tick();

    // 4: LSB first 0x01, then 0x80 loaded in the done cycle
    ser_en_l = 1'b1;
    w = 8'h01;
    load_valid_l = 1'b1; load_data_l = w;
    tick();
    load_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_bit = {7'd0, w[i]};
      chk($sformatf("lsb01_bit%0d", i), st_lsb(), {3'b000, exp_bit[0], 4'b1100});
      tick();
    end
    chk("lsb01_done", {6'd0, done_l, load_ready_l}, 8'b0000_0011);
    w = 8'h80;
    load_valid_l = 1'b1; load_data_l = w;
    tick();
    load_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_bit = {7'd0, w[i]};
      chk($sformatf("lsb80_bit%0d", i), st_lsb(), {3'b000, exp_bit[0], 4'b1100});
      tick();
    end
    chk("lsb80_done", st_lsb(), 8'b000_0_0_0_1_1);
    ser_en_l = 1'b0;
    tick();

    // 5: 0xFF with a load attempt of 0x00 mid-word
    ser_en = 1'b1;
    load_valid = 1'b1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ff_bit%0d", i), st_msb(), 8'b000_1_1_1_0_0);
      if (i == 3) begin
        load_valid = 1'b1; load_data = 8'h00;
      end else begin
        load_valid = 1'b0;
      end
      tick();
    end
    chk("ff_done", st_msb(), 8'b000_0_0_0_1_1);
    tick();
    chk("ff_no_reload", st_msb(), 8'b000_0_0_0_0_1);

    // 6: 0xF0 aborted by clr after bit 2
    load_valid = 1'b1; load_data = 8'hF0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("f0_bit%0d", i), st_msb(), 8'b000_1_1_1_0_0);
      if (i == 2) clr = 1'b1;
      tick();
    end
    clr = 1'b0;
    chk("f0_abort", st_msb(), 8'b000_0_0_0_0_1);
    tick();
    chk("f0_no_done", st_msb(), 8'b000_0_0_0_0_1);

    // clr and load_valid on the same edge: no load
    clr = 1'b1; load_valid = 1'b1; load_data = 8'hAA;
    tick();
    clr = 1'b0; load_valid = 1'b0;
    chk("clr_beats_load", st_msb(), 8'b000_0_0_0_0_1);
    tick();
    chk("clr_beats_load_after", st_msb(), 8'b000_0_0_0_0_1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
